spi_tx_engine: RTL and testbench

- Parametrised successor to the single-mode SPI serializer.
- Pops words from an upstream first-word-fall-through (FWFT) FIFO and shifts them out as SPI frames with chip select.
- Adds runtime SPI mode (CPOL/CPHA), bit order, a programmable sclk divider and inter-frame gap.
- Sits between the TX FIFO and the SPI pads.

---
 rtl/spi_tx_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_tx_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_engine.sv
// SPI master transmitter: pops words from a FWFT FIFO and shifts them out with runtime CPOL/CPHA/bit order.
// Define SPI_MISO_RX_EN to add the miso receive path (rx_data/rx_valid).
module spi_tx_engine #(
   parameter int DATAWIDTH       = 32,
   parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH),
   parameter int CLKDIV          = 2,
   parameter int GAPCYCLES       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 empty,
   input  logic [DATAWIDTH-1:0] read_data,
   output logic                 rd_en,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic                 lsb_first,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 cs_n,
   output logic                 busy,
`ifdef SPI_MISO_RX_EN
   input  logic                 miso,
   output logic [DATAWIDTH-1:0] rx_data,
   output logic                 rx_valid,
`endif
   output logic                 done
);

   localparam int CNTMAX = (CLKDIV > GAPCYCLES) ? CLKDIV : GAPCYCLES;
   localparam int CNTW   = $clog2(CNTMAX + 1);
   localparam int HALFW  = BITCOUNTERWIDTH + 1;
   localparam logic [CNTW-1:0]            DIV_LAST  = CNTW'(CLKDIV - 1);
   localparam logic [CNTW-1:0]            GAP_LAST  = CNTW'(GAPCYCLES - 1);
   localparam logic [HALFW-1:0]           HALF_LAST = HALFW'(2 * DATAWIDTH - 1);
   localparam logic [BITCOUNTERWIDTH-1:0] BIT_LAST  = BITCOUNTERWIDTH'(DATAWIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t                     r_state, w_state_nxt;
   logic [CNTW-1:0]            r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [HALFW-1:0]           r_half, w_half_nxt;
   logic [BITCOUNTERWIDTH-1:0] r_bit, w_bit_nxt;
   logic [DATAWIDTH-1:0]       r_data, w_data_nxt;
   logic                       r_cpol, w_cpol_nxt;
   logic                       r_cpha, w_cpha_nxt;
   logic                       r_lsb, w_lsb_nxt;
   logic                       r_rd_en, w_rd_en_nxt;
   logic                       r_sclk, w_sclk_nxt;
   logic                       r_mosi, w_mosi_nxt;
   logic                       r_cs_n, w_cs_n_nxt;
   logic                       r_busy, w_busy_nxt;
   logic                       r_done, w_done_nxt;

   function automatic logic [BITCOUNTERWIDTH-1:0] bit_pos(input logic lsb,
                                                         input logic [BITCOUNTERWIDTH-1:0] idx);
      return lsb ? idx : (BIT_LAST - idx);
   endfunction

   function automatic logic pick_bit(input logic [DATAWIDTH-1:0] d, input logic lsb,
                                     input logic [BITCOUNTERWIDTH-1:0] idx);
      return d[bit_pos(lsb, idx)];
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_half  <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_rd_en <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_half  <= w_half_nxt;
         r_bit   <= w_bit_nxt;
         r_data  <= w_data_nxt;
         r_cpol  <= w_cpol_nxt;
         r_cpha  <= w_cpha_nxt;
         r_lsb   <= w_lsb_nxt;
         r_rd_en <= w_rd_en_nxt;
         r_sclk  <= w_sclk_nxt;
         r_mosi  <= w_mosi_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cnt_inc   = r_cnt + 1'b1;
      w_half_nxt  = r_half;
      w_bit_nxt   = r_bit;
      w_data_nxt  = r_data;
      w_cpol_nxt  = r_cpol;
      w_cpha_nxt  = r_cpha;
      w_lsb_nxt   = r_lsb;
      w_rd_en_nxt = 1'b0;
      w_sclk_nxt  = r_sclk;
      w_mosi_nxt  = r_mosi;
      w_cs_n_nxt  = r_cs_n;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sclk_nxt = cpol;
            w_cs_n_nxt = 1'b1;
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
            if (!empty) begin
               w_state_nxt = S_SETUP;
               w_rd_en_nxt = 1'b1;
               w_data_nxt  = read_data;
               w_cpol_nxt  = cpol;
               w_cpha_nxt  = cpha;
               w_lsb_nxt   = lsb_first;
               w_cs_n_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
               w_bit_nxt   = '0;
               w_half_nxt  = '0;
               if (!cpha) w_mosi_nxt = pick_bit(read_data, lsb_first, '0);
            end
         end
         S_SETUP: begin
            if (r_cnt == DIV_LAST) begin
               w_state_nxt = S_SHIFT;
               w_cnt_nxt   = '0;
               w_half_nxt  = '0;
               w_sclk_nxt  = ~r_cpol;
               if (r_cpha) w_mosi_nxt = pick_bit(r_data, r_lsb, '0);
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         S_SHIFT: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt_nxt = '0;
               if (r_half == HALF_LAST) begin
                  w_state_nxt = S_HOLD;
                  if (CLKDIV == 1) w_done_nxt = 1'b1;
               end else begin
                  w_half_nxt = r_half + 1'b1;
                  w_sclk_nxt = ~r_sclk;
                  // even half-periods begin on a leading edge, odd ones on a trailing edge
                  if (!w_half_nxt[0]) begin
                     if (r_cpha) begin
                        w_bit_nxt  = w_half_nxt[HALFW-1:1];
                        w_mosi_nxt = pick_bit(r_data, r_lsb, w_bit_nxt);
                     end
                  end else if (!r_cpha && r_bit != BIT_LAST) begin
                     w_bit_nxt  = r_bit + 1'b1;
                     w_mosi_nxt = pick_bit(r_data, r_lsb, w_bit_nxt);
                  end
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         S_HOLD: begin
            w_sclk_nxt = r_cpol;
            if (r_cnt == DIV_LAST) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
               w_cs_n_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == DIV_LAST) w_done_nxt = 1'b1;
            end
         end
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef SPI_MISO_RX_EN
   logic [DATAWIDTH-1:0]       r_rx_sh, w_rx_sh_nxt, r_rx_data;
   logic                       r_rx_valid;
   logic [HALFW-1:0]           w_half_inc;
   logic                       w_smp;
   logic [BITCOUNTERWIDTH-1:0] w_smp_idx;

   // sample edges: leading when cpha=0, trailing when cpha=1
   always_comb begin
      w_half_inc  = r_half + 1'b1;
      w_smp       = 1'b0;
      w_smp_idx   = '0;
      w_rx_sh_nxt = r_rx_sh;
      if (r_state == S_SETUP && r_cnt == DIV_LAST && !r_cpha) begin
         w_smp = 1'b1;
      end else if (r_state == S_SHIFT && r_cnt == DIV_LAST && r_half != HALF_LAST &&
                   w_half_inc[0] == r_cpha) begin
         w_smp     = 1'b1;
         w_smp_idx = w_half_inc[HALFW-1:1];
      end
      if (w_smp) w_rx_sh_nxt[bit_pos(r_lsb, w_smp_idx)] = miso;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_sh    <= w_rx_sh_nxt;
         r_rx_valid <= w_done_nxt;
         if (w_done_nxt) r_rx_data <= r_rx_sh;
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
`endif

   assign rd_en = r_rd_en;
   assign sclk  = r_sclk;
   assign mosi  = r_mosi;
   assign cs_n  = r_cs_n;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_spi_tx_engine.sv
// Directed bench for spi_tx_engine: FWFT FIFO model plus a per-cycle monitor of the SPI pins.
module tb_spi_tx_engine;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          empty;
   logic [DW-1:0] read_data;
   logic          rd_en;
   logic          cpol, cpha, lsb_first;
   logic          sclk, mosi, cs_n, busy, done;
`ifdef SPI_MISO_RX_EN
   logic          miso;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   assign miso = mosi;
`endif

   always #5 clk = ~clk;

   spi_tx_engine #(.DATAWIDTH(DW), .CLKDIV(2), .GAPCYCLES(2)) dut (
      .clk(clk), .rst(rst), .empty(empty), .read_data(read_data), .rd_en(rd_en),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
`ifdef SPI_MISO_RX_EN
      .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
`endif
      .done(done)
   );

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] fifo[$];
   logic [DW-1:0] frame_q[$];
   int            gap_q[$];
   int            rise_q[$];
   int            n_rd = 0, n_done = 0, n_viol = 0, n_frames = 0;
   int            low_run = 0, gap_run = 0, low_len_last = 0, n_rise = 0;
   logic          prev_cs_n = 1'b1, prev_sclk = 1'b0;
   logic          last_low_done = 1'b0, done_at_end = 1'b0, sclk_after = 1'b0;
   logic [DW-1:0] rx_sh = '0;
`ifdef SPI_MISO_RX_EN
   int            n_rxv_mis = 0;
   logic [DW-1:0] rx_last = '0;
`endif

   task automatic fifo_drive();
      empty     = (fifo.size() == 0);
      read_data = (fifo.size() == 0) ? '0 : fifo[0];
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo.push_back(w);
      fifo_drive();
   endtask

   // advance one clock, apply the FIFO pop, then observe the pins
   task automatic step();
      logic pop, was_empty;
      pop = rd_en;
      was_empty = empty;
      @(posedge clk);
      #1;
      if (pop && fifo.size() > 0) void'(fifo.pop_front());
      fifo_drive();
      if (rd_en) begin
         n_rd++;
         if (was_empty) n_viol++;
      end
      if (done) n_done++;
`ifdef SPI_MISO_RX_EN
      if (rx_valid !== done) n_rxv_mis++;
      if (rx_valid) rx_last = rx_data;
`endif
      if (cs_n === 1'b0) begin
         if (prev_cs_n) begin
            gap_q.push_back(gap_run);
            low_run = 0;
            n_rise  = 0;
            rx_sh   = '0;
         end
         low_run++;
         last_low_done = done;
         if (sclk && !prev_sclk) begin
            rx_sh = {rx_sh[DW-2:0], mosi};
            n_rise++;
         end
      end else begin
         if (!prev_cs_n) begin
            frame_q.push_back(rx_sh);
            rise_q.push_back(n_rise);
            low_len_last = low_run;
            done_at_end  = last_low_done;
            sclk_after   = sclk;
            n_frames++;
            gap_run = 0;
         end
         gap_run++;
      end
      prev_cs_n = cs_n;
      prev_sclk = sclk;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (n_frames < target && k < budget) begin
         step();
         k++;
      end
      chk_eq(tag, 64'(n_frames), 64'(target));
   endtask

   task automatic clear_q();
      frame_q.delete();
      gap_q.delete();
      rise_q.delete();
   endtask

   initial begin
      int rd0, dn0, f0, k;
      rst = 1'b1;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
      fifo_drive();
      #2 rst = 1'b0;
      #1;
      chk_eq("rst_rd_en", 64'(rd_en), 64'd0);
      chk_eq("rst_sclk",  64'(sclk),  64'd0);
      chk_eq("rst_mosi",  64'(mosi),  64'd0);
      chk_eq("rst_cs_n",  64'(cs_n),  64'd1);
      chk_eq("rst_busy",  64'(busy),  64'd0);
      chk_eq("rst_done",  64'(done),  64'd0);
`ifdef SPI_MISO_RX_EN
      chk_eq("rst_rx_valid", 64'(rx_valid), 64'd0);
      chk_eq("rst_rx_data",  64'(rx_data),  64'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b1;

      // empty FIFO: nothing happens
      rd0 = n_rd;
      steps(5);
      chk_eq("idle_rd_en_count", 64'(n_rd - rd0), 64'd0);
      chk_eq("idle_cs_n", 64'(cs_n), 64'd1);
      chk_eq("idle_busy", 64'(busy), 64'd0);
      chk_eq("idle_sclk", 64'(sclk), 64'd0);

      // mode 0, MSB first
      clear_q();
      rd0 = n_rd; dn0 = n_done; f0 = n_frames;
      push(32'hA5A5_0F0F);
      wait_frames(f0 + 1, 400, "m0_frame_seen");
      steps(5);
      chk_eq("m0_rd_en_count", 64'(n_rd - rd0), 64'd1);
      chk_eq("m0_data", 64'(frame_q[0]), 64'hA5A5_0F0F);
      chk_eq("m0_rises", 64'(rise_q[0]), 64'd32);
      chk_eq("m0_cs_low_len", 64'(low_len_last), 64'd132);
      chk_eq("m0_done_count", 64'(n_done - dn0), 64'd1);
      chk_eq("m0_done_at_last_low", 64'(done_at_end), 64'd1);

      // mode 3, LSB first
      cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1;
      steps(2);
      chk_eq("m3_sclk_idle_high", 64'(sclk), 64'd1);
      clear_q();
      f0 = n_frames;
      push(32'h0000_0001);
      wait_frames(f0 + 1, 400, "m3_frame_seen");
      chk_eq("m3_bits", 64'(frame_q[0]), 64'h8000_0000);
      chk_eq("m3_rises", 64'(rise_q[0]), 64'd32);
      chk_eq("m3_cs_low_len", 64'(low_len_last), 64'd132);
      chk_eq("m3_sclk_after", 64'(sclk_after), 64'd1);
      steps(5);
      chk_eq("m3_sclk_idle_after", 64'(sclk), 64'd1);

      // three back-to-back words, mode 0
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
      steps(2);
      clear_q();
      rd0 = n_rd; f0 = n_frames;
      push(32'h1); push(32'h2); push(32'h3);
      wait_frames(f0 + 3, 700, "b2b_frames_seen");
      steps(5);
      chk_eq("b2b_rd_en_count", 64'(n_rd - rd0), 64'd3);
      chk_eq("b2b_word0", 64'(frame_q[0]), 64'h1);
      chk_eq("b2b_word1", 64'(frame_q[1]), 64'h2);
      chk_eq("b2b_word2", 64'(frame_q[2]), 64'h3);
      chk_eq("b2b_gap1", 64'(gap_q[1]), 64'd3);
      chk_eq("b2b_gap2", 64'(gap_q[2]), 64'd3);

      // mode 1 with cpol flipped mid-frame
      cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0;
      steps(2);
      clear_q();
      f0 = n_frames;
      push(32'h3C5A_96E1);
      k = 0;
      while (cs_n !== 1'b0 && k < 20) begin step(); k++; end
      steps(20);
      cpol = 1'b1;
      wait_frames(f0 + 1, 400, "m1_frame_seen");
      chk_eq("m1_data", 64'(frame_q[0]), 64'h3C5A_96E1);
      chk_eq("m1_rises", 64'(rise_q[0]), 64'd32);
      chk_eq("m1_cs_low_len", 64'(low_len_last), 64'd132);
      chk_eq("m1_sclk_after", 64'(sclk_after), 64'd0);
      steps(5);
      chk_eq("m1_sclk_idle_new_cpol", 64'(sclk), 64'd1);

      // reset at bit 10 of a frame
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
      steps(2);
      clear_q();
      rd0 = n_rd; dn0 = n_done;
      push(32'hC3C3_3C3C);
      push(32'h1234_5678);
      k = 0;
      while (!(cs_n === 1'b0 && n_rise == 10) && k < 300) begin step(); k++; end
      chk_eq("rst_reach_bit10", 64'(n_rise), 64'd10);
      rst = 1'b0;
      #1;
      chk_eq("midrst_cs_n", 64'(cs_n), 64'd1);
      chk_eq("midrst_sclk", 64'(sclk), 64'd0);
      chk_eq("midrst_busy", 64'(busy), 64'd0);
      chk_eq("midrst_done", 64'(done), 64'd0);
      chk_eq("midrst_mosi", 64'(mosi), 64'd0);
      steps(4);
      chk_eq("midrst_no_done", 64'(n_done - dn0), 64'd0);
      rst = 1'b1;
      clear_q();
      f0 = n_frames;
      wait_frames(f0 + 1, 400, "postrst_frame_seen");
      chk_eq("postrst_data", 64'(frame_q[0]), 64'h1234_5678);
      chk_eq("postrst_rd_en_count", 64'(n_rd - rd0), 64'd2);
      chk_eq("postrst_done_count", 64'(n_done - dn0), 64'd1);
      steps(5);

`ifdef SPI_MISO_RX_EN
      // loopback receive in two modes
      clear_q();
      f0 = n_frames;
      push(32'hDEAD_BEEF);
      wait_frames(f0 + 1, 400, "rx_m0_frame_seen");
      steps(2);
      chk_eq("rx_m0_data", 64'(rx_last), 64'hDEAD_BEEF);
      cpha = 1'b1; lsb_first = 1'b1;
      rx_last = '0;
      f0 = n_frames;
      push(32'h0BAD_F00D);
      wait_frames(f0 + 1, 400, "rx_m1_frame_seen");
      steps(2);
      chk_eq("rx_m1_data", 64'(rx_last), 64'h0BAD_F00D);
      chk_eq("rx_valid_with_done", 64'(n_rxv_mis), 64'd0);
`endif

      chk_eq("rd_en_while_empty", 64'(n_viol), 64'd0);
      chk_eq("fifo_drained", 64'(fifo.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
